// File: rtl/rtc_pkg.sv
// ---------------------------------------------------------------------------
// rtc_pkg
// Shared definitions for the RTC block and its alarm scheduler.
//   - APB register offsets of the RTC front-end, including the alarm slot
//     window (one 16-byte stride per slot: CFG, CMP, INTV words)
//   - rtc_slot_t : one alarm slot as held by the scheduler
//   - scan_state_t : state of the per-tick slot scanner
// ---------------------------------------------------------------------------
package rtc_pkg;

   // Widest count the slot storage supports; the scheduler's CNT_WIDTH
   // must not exceed this.
   localparam int RTC_CNT_W = 32;

   // Register map of the RTC front-end
   localparam logic [7:0] REG_CTRL        = 8'h00;
   localparam logic [7:0] REG_PSCR        = 8'h04;
   localparam logic [7:0] REG_CNT         = 8'h08;
   localparam logic [7:0] REG_DIV         = 8'h0C;
   localparam logic [7:0] REG_ALRM        = 8'h10;
   localparam logic [7:0] REG_SLOT_BASE   = 8'h40;
   localparam int         REG_SLOT_STRIDE = 16;

   // Word offsets inside one slot's window
   localparam logic [3:0] SLOT_OFS_CFG  = 4'h0;   // bit0 en, bit1 per
   localparam logic [3:0] SLOT_OFS_CMP  = 4'h4;
   localparam logic [3:0] SLOT_OFS_INTV = 4'h8;

   typedef struct packed {
      logic                 en;
      logic                 per;
      logic [RTC_CNT_W-1:0] cmp;
      logic [RTC_CNT_W-1:0] intv;
   } rtc_slot_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } scan_state_t;

   // Byte address of a word inside the slot window
   function automatic logic [7:0] slot_reg_addr(input int idx, input logic [3:0] ofs);
      return REG_SLOT_BASE + 8'(idx * REG_SLOT_STRIDE) + {4'h0, ofs};
   endfunction

endpackage

// File: rtl/rtc_alarm_sched_rr_arb.sv
// ---------------------------------------------------------------------------
// rtc_rr_arb
// Combinational N-way round-robin picker. Returns the first set bit of pend
// strictly after position last, searching circularly (last itself is
// checked last). N must be a power of two so index arithmetic wraps freely.
//   pend  : request vector
//   last  : index granted most recently
//   idx   : selected index (0 when valid is low)
//   valid : at least one request present
// ---------------------------------------------------------------------------
module rtc_rr_arb
   import rtc_pkg::*;
#(
   parameter  int N     = 4,
   localparam int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     pend,
   input  logic [IDX_W-1:0] last,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      // Offsets 1..N; offset N wraps back onto last itself.
      for (int k = 1; k <= N; k++) begin
         cand = last + IDX_W'(k);
         if (!valid && pend[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/rtc_alarm_sched.sv
// ---------------------------------------------------------------------------
// rtc_alarm_sched
// Multi-slot alarm scheduler running beside the RTC counter. On each tick the
// counter value is snapshotted and every slot is compared against it, one
// slot per cycle. Matches set a per-slot pending flag; pending slots are
// presented one at a time on irq_o/irq_id_o in round-robin order and
// retired with irq_ack_i.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cnt_i, tick_i         RTC count and its one-cycle advance pulse
//   cfg_we_i .. cfg_intv_i slot configuration write (any state)
//   irq_ack_i             retire the presented slot
//   clr_miss_i            clear the sticky miss flag
//   irq_o, irq_id_o       registered grant and its slot index
//   pend_o, ovr_o, en_o   per-slot pending / sticky overrun / enable
//   busy_o                scan in progress
//   miss_o                sticky: a tick arrived while scanning
// ---------------------------------------------------------------------------
module rtc_alarm_sched
   import rtc_pkg::*;
#(
   parameter  int NUM_SLOTS = 4,
   parameter  int CNT_WIDTH = 32,
   localparam int IDX_W     = $clog2(NUM_SLOTS)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [CNT_WIDTH-1:0] cnt_i,
   input  logic                 tick_i,
   input  logic                 cfg_we_i,
   input  logic [IDX_W-1:0]     cfg_idx_i,
   input  logic                 cfg_en_i,
   input  logic                 cfg_per_i,
   input  logic [CNT_WIDTH-1:0] cfg_cmp_i,
   input  logic [CNT_WIDTH-1:0] cfg_intv_i,
   input  logic                 irq_ack_i,
   input  logic                 clr_miss_i,
   output logic                 irq_o,
   output logic [IDX_W-1:0]     irq_id_o,
   output logic [NUM_SLOTS-1:0] pend_o,
   output logic [NUM_SLOTS-1:0] ovr_o,
   output logic [NUM_SLOTS-1:0] en_o,
   output logic                 busy_o,
   output logic                 miss_o
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

   // ---------------------------------------------------------------------
   // Scan FSM
   // ---------------------------------------------------------------------
   scan_state_t          state_reg, state_next;
   logic [IDX_W-1:0]     idx_reg, idx_next;
   logic [CNT_WIDTH-1:0] snap_reg, snap_next;
   logic                 miss_set;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= ST_IDLE;
         idx_reg   <= '0;
         snap_reg  <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         snap_reg  <= snap_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      snap_next  = snap_reg;
      miss_set   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (tick_i) begin
               snap_next  = cnt_i;
               idx_next   = '0;
               state_next = ST_SCAN;
            end
         end
         ST_SCAN: begin
            // A tick here cannot be serviced; it is only recorded.
            miss_set = tick_i;
            idx_next = idx_reg + 1'b1;
            if (idx_reg == LAST_IDX) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Slot storage and per-slot flags
   // ---------------------------------------------------------------------
   rtc_slot_t            slot_reg [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] pend_reg, ovr_reg;
   logic [NUM_SLOTS-1:0] cfg_clr;
   logic                 scan_hit;

   logic                 grant_valid_reg;
   logic [IDX_W-1:0]     grant_id_reg;
   logic [IDX_W-1:0]     last_reg;

   // Match of the slot currently under the scanner
   assign scan_hit = (state_reg == ST_SCAN) && slot_reg[idx_reg].en &&
                     (slot_reg[idx_reg].cmp[CNT_WIDTH-1:0] == snap_reg);

   for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      logic                 cfg_hit, set_hit, ack_hit;
      logic [CNT_WIDTH-1:0] cmp_next;

      assign cfg_hit     = cfg_we_i && (cfg_idx_i == IDX_W'(gi));
      assign set_hit     = scan_hit && (idx_reg == IDX_W'(gi));
      assign ack_hit     = grant_valid_reg && irq_ack_i && (grant_id_reg == IDX_W'(gi));
      assign cfg_clr[gi] = cfg_hit;
      // Periodic reload wraps modulo 2^CNT_WIDTH.
      assign cmp_next    = slot_reg[gi].cmp[CNT_WIDTH-1:0] + slot_reg[gi].intv[CNT_WIDTH-1:0];

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            slot_reg[gi] <= '0;
         end else if (cfg_hit) begin
            // A write to the slot under the scanner discards its match.
            slot_reg[gi].en   <= cfg_en_i;
            slot_reg[gi].per  <= cfg_per_i;
            slot_reg[gi].cmp  <= RTC_CNT_W'(cfg_cmp_i);
            slot_reg[gi].intv <= RTC_CNT_W'(cfg_intv_i);
         end else if (set_hit) begin
            if (slot_reg[gi].per) begin
               slot_reg[gi].cmp <= RTC_CNT_W'(cmp_next);
            end else begin
               slot_reg[gi].en <= 1'b0;
            end
         end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            pend_reg[gi] <= 1'b0;
            ovr_reg[gi]  <= 1'b0;
         end else if (cfg_hit) begin
            pend_reg[gi] <= 1'b0;
            ovr_reg[gi]  <= 1'b0;
         end else if (set_hit) begin
            // A set coinciding with the ack of the same slot replaces the
            // retired event rather than overrunning it.
            pend_reg[gi] <= 1'b1;
            if (pend_reg[gi] && !ack_hit) begin
               ovr_reg[gi] <= 1'b1;
            end
         end else if (ack_hit) begin
            pend_reg[gi] <= 1'b0;
         end
      end

      assign en_o[gi] = slot_reg[gi].en;
   end

   // ---------------------------------------------------------------------
   // Round-robin grant
   // ---------------------------------------------------------------------
   logic [IDX_W-1:0] arb_idx;
   logic             arb_valid;

   // Slots being reconfigured this cycle are not eligible.
   rtc_rr_arb #(
      .N (NUM_SLOTS)
   ) u_arb (
      .pend  (pend_reg & ~cfg_clr),
      .last  (last_reg),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         grant_valid_reg <= 1'b0;
         grant_id_reg    <= '0;
         last_reg        <= LAST_IDX;
      end else if (grant_valid_reg) begin
         if (cfg_we_i && (cfg_idx_i == grant_id_reg)) begin
            // Reconfigured under the grant: withdraw, pointer untouched.
            grant_valid_reg <= 1'b0;
         end else if (irq_ack_i) begin
            grant_valid_reg <= 1'b0;
            last_reg        <= grant_id_reg;
         end
      end else if (arb_valid) begin
         grant_valid_reg <= 1'b1;
         grant_id_reg    <= arb_idx;
      end
   end

   // ---------------------------------------------------------------------
   // Sticky miss flag; a set beats a simultaneous clear.
   // ---------------------------------------------------------------------
   logic miss_reg;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         miss_reg <= 1'b0;
      end else if (miss_set) begin
         miss_reg <= 1'b1;
      end else if (clr_miss_i) begin
         miss_reg <= 1'b0;
      end
   end

   assign irq_o    = grant_valid_reg;
   assign irq_id_o = grant_id_reg;
   assign pend_o   = pend_reg;
   assign ovr_o    = ovr_reg;
   assign busy_o   = (state_reg == ST_SCAN);
   assign miss_o   = miss_reg;

endmodule

// File: tb/tb_rtc_alarm_sched.sv
// ---------------------------------------------------------------------------
// tb_rtc_alarm_sched
// Directed scenarios followed by a randomized phase, all checked against a
// transaction-level model of the alarm slots, flags and round-robin grant.
// ---------------------------------------------------------------------------
module tb_rtc_alarm_sched;

   localparam int N = 4;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [31:0]   cnt_i;
   logic          tick_i;
   logic          cfg_we_i;
   logic [1:0]    cfg_idx_i;
   logic          cfg_en_i;
   logic          cfg_per_i;
   logic [31:0]   cfg_cmp_i;
   logic [31:0]   cfg_intv_i;
   logic          irq_ack_i;
   logic          clr_miss_i;
   logic          irq_o;
   logic [1:0]    irq_id_o;
   logic [N-1:0]  pend_o;
   logic [N-1:0]  ovr_o;
   logic [N-1:0]  en_o;
   logic          busy_o;
   logic          miss_o;

   rtc_alarm_sched #(
      .NUM_SLOTS (N),
      .CNT_WIDTH (32)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .cnt_i      (cnt_i),
      .tick_i     (tick_i),
      .cfg_we_i   (cfg_we_i),
      .cfg_idx_i  (cfg_idx_i),
      .cfg_en_i   (cfg_en_i),
      .cfg_per_i  (cfg_per_i),
      .cfg_cmp_i  (cfg_cmp_i),
      .cfg_intv_i (cfg_intv_i),
      .irq_ack_i  (irq_ack_i),
      .clr_miss_i (clr_miss_i),
      .irq_o      (irq_o),
      .irq_id_o   (irq_id_o),
      .pend_o     (pend_o),
      .ovr_o      (ovr_o),
      .en_o       (en_o),
      .busy_o     (busy_o),
      .miss_o     (miss_o)
   );

   always #5 clk_i = ~clk_i;

   int tests_run    = 0;
   int tests_failed = 0;

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   bit          m_en   [N];
   bit          m_per  [N];
   logic [31:0] m_cmp  [N];
   logic [31:0] m_intv [N];
   bit          m_pend [N];
   bit          m_ovr  [N];
   bit          m_gv;
   int          m_id;
   int          m_last;
   bit          m_miss;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < N; i++) begin
         m_en[i] = 0; m_per[i] = 0; m_cmp[i] = '0; m_intv[i] = '0;
         m_pend[i] = 0; m_ovr[i] = 0;
      end
      m_gv = 0; m_id = 0; m_last = N - 1; m_miss = 0;
   endfunction

   // Idle grant: first pending slot after the last granted one, circularly.
   function automatic void m_rearb();
      if (!m_gv) begin
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (!m_gv && m_pend[j]) begin
               m_gv = 1; m_id = j;
            end
         end
      end
   endfunction

   // Whole-tick effect. With nothing presented, nothing is pending either,
   // so the scanner's in-order visit makes the lowest matching slot the
   // first one presented.
   function automatic void m_tick(input logic [31:0] c);
      int first;
      first = -1;
      for (int i = 0; i < N; i++) begin
         if (m_en[i] && m_cmp[i] == c) begin
            if (m_pend[i]) m_ovr[i] = 1;
            m_pend[i] = 1;
            if (m_per[i]) m_cmp[i] = m_cmp[i] + m_intv[i];
            else          m_en[i]  = 0;
            if (first < 0) first = i;
         end
      end
      if (!m_gv && first >= 0) begin
         m_gv = 1; m_id = first;
      end
   endfunction

   task automatic check_all(input string tag);
      logic [N-1:0] ep, eo, ee;
      for (int i = 0; i < N; i++) begin
         ep[i] = m_pend[i]; eo[i] = m_ovr[i]; ee[i] = m_en[i];
      end
      check({tag, ".pend"}, 32'(pend_o), 32'(ep));
      check({tag, ".ovr"},  32'(ovr_o),  32'(eo));
      check({tag, ".en"},   32'(en_o),   32'(ee));
      check({tag, ".irq"},  32'(irq_o),  32'(m_gv));
      if (m_gv) check({tag, ".id"}, 32'(irq_id_o), 32'(m_id));
      check({tag, ".busy"}, 32'(busy_o), 32'd0);
      check({tag, ".miss"}, 32'(miss_o), 32'(m_miss));
   endtask

   // ------------------------------------------------------------------
   // Stimulus tasks
   // ------------------------------------------------------------------
   task automatic do_tick(input logic [31:0] c);
      @(negedge clk_i); tick_i = 1'b1; cnt_i = c;
      @(negedge clk_i); tick_i = 1'b0;
      m_tick(c);
      repeat (N + 2) @(negedge clk_i);
      $display("[TB] tick cnt=0x%08h pend=%b irq=%0d id=%0d", c, pend_o, irq_o, irq_id_o);
      check_all("tick");
   endtask

   task automatic do_cfg(input int s, input bit en, input bit per,
                         input logic [31:0] cmp, input logic [31:0] intv);
      @(negedge clk_i);
      cfg_we_i = 1'b1; cfg_idx_i = 2'(s); cfg_en_i = en; cfg_per_i = per;
      cfg_cmp_i = cmp; cfg_intv_i = intv;
      @(negedge clk_i); cfg_we_i = 1'b0;
      m_en[s] = en; m_per[s] = per; m_cmp[s] = cmp; m_intv[s] = intv;
      m_pend[s] = 0; m_ovr[s] = 0;
      if (m_gv && m_id == s) m_gv = 0;
      @(negedge clk_i);
      m_rearb();
      $display("[TB] cfg slot=%0d en=%0d per=%0d cmp=0x%08h intv=0x%08h", s, en, per, cmp, intv);
      check_all("cfg");
   endtask

   task automatic do_ack();
      @(negedge clk_i); irq_ack_i = 1'b1;
      @(negedge clk_i); irq_ack_i = 1'b0;
      check("ack.irq_low", 32'(irq_o), 32'd0);
      if (m_gv) begin
         m_pend[m_id] = 0; m_last = m_id; m_gv = 0;
      end
      @(negedge clk_i);
      m_rearb();
      $display("[TB] ack -> irq=%0d id=%0d pend=%b", irq_o, irq_id_o, pend_o);
      check_all("ack");
   endtask

   task automatic do_clr_miss();
      @(negedge clk_i); clr_miss_i = 1'b1;
      @(negedge clk_i); clr_miss_i = 1'b0;
      m_miss = 0;
      $display("[TB] clr_miss -> miss=%0d", miss_o);
      check_all("clr_miss");
   endtask

   // ------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------
   initial begin
      int order [3];
      int op, s;

      rst_i = 1'b1; cnt_i = '0; tick_i = 1'b0; cfg_we_i = 1'b0; cfg_idx_i = '0;
      cfg_en_i = 1'b0; cfg_per_i = 1'b0; cfg_cmp_i = '0; cfg_intv_i = '0;
      irq_ack_i = 1'b0; clr_miss_i = 1'b0;
      m_reset();
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      check_all("reset");
      check("reset.id", 32'(irq_id_o), 32'd0);

      // One-shot slot 0 with cycle-exact latency
      do_cfg(0, 1, 0, 32'h10, 32'h0);
      do_tick(32'h0F);
      @(negedge clk_i); tick_i = 1'b1; cnt_i = 32'h10;
      @(negedge clk_i); tick_i = 1'b0;
      check("lat.pend_pre", 32'(pend_o), 32'h0);
      @(negedge clk_i);
      check("lat.pend", 32'(pend_o), 32'h1);
      check("lat.irq_early", 32'(irq_o), 32'd0);
      @(negedge clk_i);
      check("lat.irq", 32'(irq_o), 32'd1);
      m_tick(32'h10);
      repeat (N) @(negedge clk_i);
      check_all("oneshot");
      check("oneshot.en0", 32'(en_o[0]), 32'd0);
      do_ack();
      do_tick(32'h110);

      // Periodic slot 2, including wrap of the reload
      do_cfg(2, 1, 1, 32'h20, 32'h10);
      for (int k = 0; k < 3; k++) begin
         do_tick(32'h20 + 32'(k) * 32'h10);
         check("per.id", 32'(irq_id_o), 32'd2);
         do_ack();
      end
      do_cfg(2, 1, 1, 32'hFFFF_FFF8, 32'h10);
      do_tick(32'hFFFF_FFF8);
      check("wrap.first", 32'(irq_id_o), 32'd2);
      do_ack();
      do_tick(32'h0000_0008);
      check("wrap.irq", 32'(irq_o), 32'd1);
      do_ack();
      do_cfg(2, 0, 0, 32'h0, 32'h0);

      // Round-robin over slots 0, 1, 3
      order = '{0, 1, 3};
      for (int r = 0; r < 2; r++) begin
         do_cfg(0, 1, 0, 32'h50 + 32'(r) * 32'h10, 32'h0);
         do_cfg(1, 1, 0, 32'h50 + 32'(r) * 32'h10, 32'h0);
         do_cfg(3, 1, 0, 32'h50 + 32'(r) * 32'h10, 32'h0);
         do_tick(32'h50 + 32'(r) * 32'h10);
         for (int k = 0; k < 3; k++) begin
            check("rr.id", 32'(irq_id_o), 32'(order[k]));
            do_ack();
         end
      end

      // Overrun with an interval of zero, cleared by reconfiguration
      do_cfg(1, 1, 1, 32'h70, 32'h0);
      do_tick(32'h70);
      do_tick(32'h70);
      check("ovr.set", 32'(ovr_o[1]), 32'd1);
      do_cfg(1, 0, 0, 32'h0, 32'h0);
      check("ovr.clr_pend", 32'(pend_o[1]), 32'd0);
      check("ovr.clr_ovr", 32'(ovr_o[1]), 32'd0);

      // Back-to-back ticks: second is missed, busy lasts N cycles
      @(negedge clk_i); tick_i = 1'b1; cnt_i = 32'h1234_0000;
      @(negedge clk_i); check("miss.busy0", 32'(busy_o), 32'd1);
      @(negedge clk_i); tick_i = 1'b0; check("miss.busy1", 32'(busy_o), 32'd1);
      @(negedge clk_i); check("miss.busy2", 32'(busy_o), 32'd1);
      @(negedge clk_i); check("miss.busy3", 32'(busy_o), 32'd1);
      @(negedge clk_i); check("miss.busy_end", 32'(busy_o), 32'd0);
      check("miss.set", 32'(miss_o), 32'd1);
      m_tick(32'h1234_0000);
      m_miss = 1;
      check_all("miss");
      do_clr_miss();

      // Reset during a scan while slot 0 is presented
      do_cfg(0, 1, 0, 32'hA0, 32'h0);
      do_cfg(1, 1, 0, 32'hA0, 32'h0);
      do_tick(32'hA0);
      do_ack();
      do_ack();                              // pointer now at slot 1
      do_cfg(0, 1, 0, 32'hB0, 32'h0);
      do_cfg(1, 1, 0, 32'hC8, 32'h0);
      do_tick(32'hB0);
      check("rst.pre_id", 32'(irq_id_o), 32'd0);
      @(negedge clk_i); tick_i = 1'b1; cnt_i = 32'hC0;
      @(negedge clk_i); tick_i = 1'b0;
      @(negedge clk_i);
      check("rst.busy_before", 32'(busy_o), 32'd1);
      #2 rst_i = 1'b1;
      #1;
      check("rst.irq", 32'(irq_o), 32'd0);
      check("rst.pend", 32'(pend_o), 32'h0);
      check("rst.busy", 32'(busy_o), 32'd0);
      check("rst.en", 32'(en_o), 32'h0);
      @(negedge clk_i); rst_i = 1'b0;
      m_reset();
      @(negedge clk_i);
      check_all("rst.after");
      do_cfg(0, 1, 0, 32'hD0, 32'h0);
      do_cfg(1, 1, 0, 32'hD0, 32'h0);
      do_cfg(2, 1, 0, 32'hD0, 32'h0);
      do_tick(32'hD0);
      check("rst.first", 32'(irq_id_o), 32'd0);
      do_cfg(0, 0, 0, 32'h0, 32'h0);         // drop grant, pointer stays at 3
      check("rst.next", 32'(irq_id_o), 32'd1);
      do_ack();
      do_ack();

      // Randomized phase: small value range so matches are frequent
      for (int it = 0; it < 60; it++) begin
         op = int'($urandom_range(0, 9));
         s  = int'($urandom_range(0, N - 1));
         if (op <= 2) begin
            do_cfg(s, ($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                   32'($urandom_range(0, 7)), 32'($urandom_range(0, 3)));
         end else if (op <= 5) begin
            do_tick(32'($urandom_range(0, 7)));
         end else if (op <= 8) begin
            do_ack();
         end else begin
            do_clr_miss();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/rtc_alarm_sched.md
Name: rtc_alarm_sched

Overview:
- Multi-slot alarm scheduler beside the RTC counter.
- Holds NUM_SLOTS compare slots, each one-shot or periodic.
- On every RTC tick, scans the slots sequentially against a snapshot of the counter and sets a per-slot pending flag on each match.
- Round-robin arbitrates pending slots onto one interrupt line with an id and acknowledge handshake, for the APB register front-end and the CPU.

Parameters:
- NUM_SLOTS, 4, number of alarm slots; power of two, 2..16
- CNT_WIDTH, 32, width of RTC count and compare values
- IDX_W, $clog2(NUM_SLOTS), slot index width (derived, not overridable)

Ports:
- clk_i  in  1  block clock (the RTC domain clock)
- rst_i  in  1  reset; asynchronous, active-high
- cnt_i  in  CNT_WIDTH  current RTC count; valid in the cycle tick_i is high
- tick_i  in  1  one-cycle pulse; the count has just advanced
- cfg_we_i  in  1  slot configuration write strobe
- cfg_idx_i  in  IDX_W  slot being written
- cfg_en_i  in  1  slot enable
- cfg_per_i  in  1  1 = periodic, 0 = one-shot
- cfg_cmp_i  in  CNT_WIDTH  compare value
- cfg_intv_i  in  CNT_WIDTH  reload interval for periodic slots
- irq_ack_i  in  1  acknowledge for the currently presented slot
- clr_miss_i  in  1  clears miss_o
- irq_o  out  1  interrupt; a grant is presented
- irq_id_o  out  IDX_W  slot index of the presented grant
- pend_o  out  NUM_SLOTS  per-slot pending flags
- ovr_o  out  NUM_SLOTS  sticky per-slot overrun flags
- en_o  out  NUM_SLOTS  per-slot enable, as currently held
- busy_o  out  1  scan in progress
- miss_o  out  1  sticky; a tick arrived during a scan

Behaviour:
- Reset values:
  - All outputs 0.
  - All slot registers (en, per, cmp, intv) 0.
  - Scan FSM in IDLE.
  - Round-robin last-grant pointer = NUM_SLOTS-1, so slot 0 has first priority.
- Scan FSM states: IDLE, SCAN.
  - IDLE with tick_i: capture snap <= cnt_i, idx <= 0, go to SCAN. busy_o is 1 from the next cycle.
  - SCAN: one slot per cycle. If en[idx] and cmp[idx] == snap, the slot matches:
    - If pend[idx] is already 1, set ovr[idx].
    - Set pend[idx].
    - Periodic slot: cmp[idx] <= cmp[idx] + intv[idx], modulo 2^CNT_WIDTH (wrap allowed).
    - One-shot slot: en[idx] <= 0.
  - SCAN at idx == NUM_SLOTS-1: go to IDLE. A scan always takes exactly NUM_SLOTS cycles.
  - tick_i while in SCAN: tick ignored, miss_o set. miss_o clears only on clr_miss_i; a set in the same cycle wins.
- Configuration write (cfg_we_i), accepted in any state:
  - Loads en, per, cmp, intv of slot cfg_idx_i.
  - Clears pend and ovr of that slot.
  - If that slot is being scanned in the same cycle, the write wins: its compare update and its pend/ovr set are discarded.
  - If that slot is the presented grant: grant dropped, irq_o low next cycle, pointer unchanged.
- Arbiter, registered grant:
  - No grant and |pend: select the first pending slot after the last-grant pointer (circular). irq_o and irq_id_o take effect the next cycle.
  - irq_id_o stays stable while irq_o is high.
  - irq_ack_i with irq_o high: clear pend[irq_id_o], pointer <= irq_id_o, irq_o low next cycle. Earliest re-grant is the cycle after that.
  - irq_ack_i with irq_o low: ignored.
  - Ack and a scan set of the same slot in the same cycle: set wins. pend stays 1, ovr is not set, grant is released.
- Latency: match in SCAN cycle k -> pend_o at k+1 -> irq_o at k+2.
- A match cmp == snap with intv = 0 periodic: slot re-matches every tick with the same value. Legal; overruns are reported.
- rst_i mid-scan or mid-grant: immediate return to reset values; no partial state survives.

Decomposition:
- Shared package rtc_pkg:
  - register offset constants (CTRL, PSCR, CNT, DIV, ALRM, plus the new ALRM slot window)
  - typedef rtc_slot_t {en, per, cmp, intv}
  - FSM state enum
- One natural sub-module: rtc_rr_arb. Parameterised N-way round-robin picker: pend vector and last pointer in, index and valid out. Purely combinational; the grant register stays in the parent.

Test Plan:
- One-shot slot 0, cmp=0x10; ticks with cnt 0x0F, 0x10 -> pend_o=0001 two cycles after slot-0 scan, irq_o=1, irq_id_o=0, en_o[0]=0; ack -> irq_o=0, no re-fire at cnt 0x110.
- Periodic slot 2, cmp=0x20, intv=0x10 -> interrupts with id 2 at cnt 0x20, 0x30, 0x40. Then cmp=0xFFFFFFF8, intv=0x10 -> fires at 0xFFFFFFF8, next at 0x00000008 (wrap).
- Slots 0,1,3 all cmp=0x50, enabled -> ids presented 0, 1, 3 across successive acks. After re-arming at 0x60 -> order 0, 1, 3 again starting after pointer=3.
- Periodic intv=0 slot 1 never acked over two ticks -> ovr_o[1]=1. cfg write to slot 1 -> pend_o[1]=0, ovr_o[1]=0.
- NUM_SLOTS=4, tick_i pulsed on consecutive cycles -> second tick ignored, miss_o=1, busy_o high for 4 cycles. clr_miss_i -> miss_o=0.
- Slot 0 presented, rst_i asserted mid-scan -> irq_o, pend_o, busy_o, en_o go to 0 asynchronously. After release, slot 0 is granted first again.
